// File: rtl/bbc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bbc_mem_ctrl
// Purpose  : Time-slices the shared 32KiB RAM between the 6502 and the CRTC,
//            translates CRTC addresses (scroll wrap, teletext) and holds the
//            system addressable latch.
// Revision : 1.0 - initial release
// ============================================================================
module bbc_mem_ctrl #(
  parameter logic [14:0] TTX_BASE = 15'h3C00
) (
  input  logic        clk16MHz,
  input  logic        RESET,
  input  logic        ph_sync,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [13:0] crtc_ma,
  input  logic [2:0]  crtc_ra,
  output logic [7:0]  vid_data,
  input  logic        la_we,
  input  logic [2:0]  la_a,
  input  logic        la_d,
  output logic [7:0]  la_q,
  output logic [14:0] ram_adr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        locked
);

  localparam logic [2:0]  c_SLOT_CPU_ADR  = 3'd0;
  localparam logic [2:0]  c_SLOT_CPU_DATA = 3'd2;
  localparam logic [2:0]  c_SLOT_VID_ADR  = 3'd4;
  localparam logic [2:0]  c_SLOT_VID_DATA = 3'd6;
  localparam logic [2:0]  c_SLOT_LAST     = 3'd7;

  localparam logic [14:0] c_WRAP_00 = 15'h4000;
  localparam logic [14:0] c_WRAP_01 = 15'h6000;
  localparam logic [14:0] c_WRAP_10 = 15'h3000;
  localparam logic [14:0] c_WRAP_11 = 15'h5800;

  logic [2:0]  r_slot;
  logic        r_locked;
  logic [14:0] r_ram_adr;
  logic        r_ram_we;
  logic [7:0]  r_ram_wdata;
  logic [7:0]  r_cpu_rdata;
  logic [7:0]  r_vid_data;
  logic [7:0]  r_la_q;

  logic        w_resync;
  logic        w_cpu_ram;
  logic [14:0] w_row_adr;
  logic [14:0] w_wrap;
  logic [14:0] w_vaddr;

  assign w_resync  = ph_sync & (r_slot != c_SLOT_LAST);
  assign w_cpu_ram = ~cpu_adr[15];

  // Screen address: teletext window, linear framestore, or framestore that
  // wraps back into the screen area sized by latch bits 5:4.
  always_comb begin
    w_row_adr = {crtc_ma[11:0], crtc_ra};
    w_wrap    = c_WRAP_00;
    case ({r_la_q[5], r_la_q[4]})
      2'b00:   w_wrap = c_WRAP_00;
      2'b01:   w_wrap = c_WRAP_01;
      2'b10:   w_wrap = c_WRAP_10;
      default: w_wrap = c_WRAP_11;
    endcase
    if (crtc_ma[13]) begin
      w_vaddr = TTX_BASE | {5'd0, crtc_ma[9:0]};
    end else if (crtc_ma[12]) begin
      w_vaddr = w_row_adr + w_wrap;
    end else begin
      w_vaddr = w_row_adr;
    end
  end

  always_ff @(posedge clk16MHz) begin
    if (RESET) begin
      r_slot      <= 3'd0;
      r_locked    <= 1'b0;
      r_ram_adr   <= 15'd0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'd0;
      r_cpu_rdata <= 8'd0;
      r_vid_data  <= 8'd0;
      r_la_q      <= 8'd0;
    end else begin
      r_ram_we <= 1'b0;

      if (ph_sync) begin
        r_slot   <= 3'd0;
        r_locked <= (r_slot == c_SLOT_LAST);
      end else begin
        r_slot <= r_slot + 3'd1;
      end

      // A misaligned sync abandons whatever this slot would have captured.
      if (!w_resync) begin
        case (r_slot)
          c_SLOT_CPU_ADR: begin
            r_ram_adr   <= cpu_adr[14:0];
            r_ram_wdata <= cpu_wdata;
            r_ram_we    <= ~cpu_rnw & w_cpu_ram;
          end
          c_SLOT_CPU_DATA: begin
            if (cpu_rnw && w_cpu_ram) begin
              r_cpu_rdata <= ram_rdata;
            end
          end
          c_SLOT_VID_ADR: begin
            r_ram_adr <= w_vaddr;
          end
          c_SLOT_VID_DATA: begin
            r_vid_data <= ram_rdata;
          end
          default: begin
          end
        endcase
      end

      if (la_we) begin
        r_la_q[la_a] <= la_d;
      end
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign vid_data  = r_vid_data;
  assign la_q      = r_la_q;
  assign ram_adr   = r_ram_adr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_bbc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbc_mem_ctrl
// Purpose  : Directed bench for bbc_mem_ctrl with a RAM model and a
//            behavioural reference compared on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bbc_mem_ctrl;

  localparam logic [14:0] TTX = 15'h3C00;

  logic        clk16MHz = 1'b0;
  logic        RESET = 1'b1;
  logic        ph_sync = 1'b0;
  logic [15:0] cpu_adr = 16'd0;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic [13:0] crtc_ma = 14'd0;
  logic [2:0]  crtc_ra = 3'd0;
  logic [7:0]  vid_data;
  logic        la_we = 1'b0;
  logic [2:0]  la_a = 3'd0;
  logic        la_d = 1'b0;
  logic [7:0]  la_q;
  logic [14:0] ram_adr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;
  logic        locked;

  int total = 0;
  int bad   = 0;

  bbc_mem_ctrl #(.TTX_BASE(TTX)) dut (
    .clk16MHz (clk16MHz),
    .RESET    (RESET),
    .ph_sync  (ph_sync),
    .cpu_adr  (cpu_adr),
    .cpu_rnw  (cpu_rnw),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .crtc_ma  (crtc_ma),
    .crtc_ra  (crtc_ra),
    .vid_data (vid_data),
    .la_we    (la_we),
    .la_a     (la_a),
    .la_d     (la_d),
    .la_q     (la_q),
    .ram_adr  (ram_adr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .locked   (locked)
  );

  always #5 clk16MHz = ~clk16MHz;

  // Initial RAM contents, known to both the RAM and the reference.
  function automatic logic [7:0] init_val(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  logic [7:0] mem    [0:32767];
  logic [7:0] shadow [0:32767];

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = init_val(15'(i));
      shadow[i] = init_val(15'(i));
    end
  end

  // Synchronous RAM: data appears the cycle after the address is sampled.
  always @(posedge clk16MHz) begin
    if (ram_we) mem[ram_adr] <= ram_wdata;
    ram_rdata <= mem[ram_adr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Screen address from the addressing rules, in plain integer arithmetic.
  function automatic logic [14:0] exp_vaddr(input logic [13:0] ma, input logic [2:0] ra,
                                            input logic [7:0] la);
    int wrap_tbl [4];
    int m;
    int line;
    wrap_tbl = '{32'h4000, 32'h6000, 32'h3000, 32'h5800};
    m = int'(ma);
    if (m >= 8192) return 15'(int'(TTX) + (m % 1024));
    line = (m % 4096) * 8 + int'(ra);
    if (m >= 4096) line = (line + wrap_tbl[{la[5], la[4]}]) % 32768;
    return 15'(line);
  endfunction

  // Reference: position within the 8-cycle period decides what happens.
  int         m_pos = 0;
  bit         m_started = 1'b0;
  logic       m_locked = 1'b0, m_we = 1'b0, m_next_we;
  logic [14:0] m_adr = 15'd0;
  logic [7:0] m_wd = 8'd0, m_rd = 8'd0, m_vid = 8'd0, m_la = 8'd0;
  logic [7:0] m_bus = 8'd0, m_bus_now;

  always @(posedge clk16MHz) begin
    m_bus_now = m_bus;
    m_bus     = shadow[m_adr];
    if (m_we) shadow[m_adr] = m_wd;
    if (RESET) begin
      m_started = 1'b1;
      m_pos = 0; m_locked = 1'b0; m_we = 1'b0; m_adr = 15'd0;
      m_wd = 8'd0; m_rd = 8'd0; m_vid = 8'd0; m_la = 8'd0;
    end else begin
      m_next_we = 1'b0;
      if (ph_sync && m_pos != 7) begin
        m_locked = 1'b0;
        m_pos    = 0;
      end else begin
        case (m_pos)
          0: begin
            m_adr = cpu_adr[14:0];
            m_wd  = cpu_wdata;
            m_next_we = !cpu_rnw && !cpu_adr[15];
          end
          2: if (cpu_rnw && !cpu_adr[15]) m_rd = m_bus_now;
          4: m_adr = exp_vaddr(crtc_ma, crtc_ra, m_la);
          6: m_vid = m_bus_now;
          default: ;
        endcase
        if (ph_sync) begin
          m_locked = 1'b1;
          m_pos    = 0;
        end else begin
          m_pos = (m_pos + 1) % 8;
        end
      end
      m_we = m_next_we;
      if (la_we) m_la[la_a] = la_d;
    end
  end

  always @(negedge clk16MHz) begin
    if (m_started) begin
      chk("cmp_cpu_rdata", 32'(cpu_rdata), 32'(m_rd));
      chk("cmp_vid_data",  32'(vid_data),  32'(m_vid));
      chk("cmp_la_q",      32'(la_q),      32'(m_la));
      chk("cmp_ram_adr",   32'(ram_adr),   32'(m_adr));
      chk("cmp_ram_we",    32'(ram_we),    32'(m_we));
      chk("cmp_ram_wdata", 32'(ram_wdata), 32'(m_wd));
      chk("cmp_locked",    32'(locked),    32'(m_locked));
    end
  end

  task automatic step();
    @(posedge clk16MHz);
    #2;
  endtask

  logic [14:0] obs_adr [8];
  logic        obs_we  [8];
  logic [7:0]  obs_rd  [8];
  logic [7:0]  obs_vid [8];
  logic        obs_lk  [8];
  int          we_cnt;

  // One sync pulse followed by slots 0..7; returns while in slot 7.
  task automatic run_period(input logic [15:0] adr, input logic rnw, input logic [7:0] wd,
                            input logic [13:0] ma, input logic [2:0] ra,
                            input logic lw, input logic [2:0] la, input logic ld);
    cpu_adr = adr; cpu_rnw = rnw; cpu_wdata = wd; crtc_ma = ma; crtc_ra = ra;
    la_we = lw; la_a = la; la_d = ld; ph_sync = 1'b1;
    step();
    ph_sync = 1'b0; la_we = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      obs_adr[i] = ram_adr; obs_we[i] = ram_we; obs_rd[i] = cpu_rdata;
      obs_vid[i] = vid_data; obs_lk[i] = locked;
      if (ram_we) we_cnt++;
      if (i < 7) step();
    end
  endtask

  // Aligned sync, then a stray sync at slot k, then 7 more cycles.
  task automatic resync_period(input int k, input logic [15:0] adr, input logic rnw,
                               input logic [7:0] wd);
    cpu_adr = adr; cpu_rnw = rnw; cpu_wdata = wd; crtc_ma = 14'd0; crtc_ra = 3'd0;
    ph_sync = 1'b1;
    step();
    ph_sync = 1'b0;
    for (int i = 0; i < k; i++) step();
    ph_sync = 1'b1;
    step();
    ph_sync = 1'b0;
  endtask

  task automatic finish_resync();
    for (int i = 0; i < 7; i++) step();
  endtask

  initial begin
    RESET = 1'b1;
    step(); step();
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    chk("rst_vid_data",  32'(vid_data),  32'h00);
    chk("rst_la_q",      32'(la_q),      32'h00);
    chk("rst_ram_adr",   32'(ram_adr),   32'h0000);
    chk("rst_ram_we",    32'(ram_we),    32'h0);
    chk("rst_locked",    32'(locked),    32'h0);
    RESET = 1'b0;

    run_period(16'h0100, 1'b1, 8'h00, 14'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("p1_unlocked", 32'(obs_lk[0]), 32'h0);

    run_period(16'h1234, 1'b0, 8'hA5, 14'h0123, 3'd5, 1'b0, 3'd0, 1'b0);
    chk("p2_locked",   32'(obs_lk[0]), 32'h1);
    chk("p2_we_slot1", 32'(obs_we[1]), 32'h1);
    chk("p2_adr_slot1",32'(obs_adr[1]),32'h1234);
    chk("p2_we_count", 32'(we_cnt),    32'd1);
    chk("p2_vaddr",    32'(obs_adr[5]),32'h091D);
    chk("p2_vid",      32'(obs_vid[7]),32'(init_val(15'h091D)));

    run_period(16'h1234, 1'b1, 8'h00, 14'h2155, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("p3_rd_slot2", 32'(obs_rd[2]), 32'h01);
    chk("p3_rd_slot3", 32'(obs_rd[3]), 32'hA5);
    chk("p3_we_count", 32'(we_cnt),    32'd0);
    chk("p3_ttx",      32'(obs_adr[5]),32'h3D55);
    chk("p3_vid",      32'(obs_vid[7]),32'(init_val(15'h3D55)));

    run_period(16'hC000, 1'b0, 8'h5A, 14'h1FFF, 3'd7, 1'b0, 3'd0, 1'b0);
    chk("p4_rom_we",   32'(we_cnt),    32'd0);
    chk("p4_wrap00",   32'(obs_adr[5]),32'h3FFF);

    run_period(16'hC000, 1'b1, 8'h00, 14'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("p5_rom_read_hold", 32'(obs_rd[7]), 32'hA5);

    run_period(16'h0100, 1'b1, 8'h00, 14'h1800, 3'd0, 1'b1, 3'd5, 1'b1);
    chk("p6_la_q",     32'(la_q),      32'h20);
    chk("p6_wrap10",   32'(obs_adr[5]),32'h7000);

    run_period(16'h0100, 1'b1, 8'h00, 14'h1800, 3'd0, 1'b1, 3'd4, 1'b1);
    chk("p7_la_q",     32'(la_q),      32'h30);
    chk("p7_wrap11",   32'(obs_adr[5]),32'h1800);

    run_period(16'h0100, 1'b1, 8'h00, 14'h1000, 3'd3, 1'b1, 3'd5, 1'b0);
    chk("p8_la_q",     32'(la_q),      32'h10);
    chk("p8_wrap01",   32'(obs_adr[5]),32'h6003);

    resync_period(3, 16'h0100, 1'b1, 8'h00);
    chk("rs3_locked",  32'(locked),    32'h0);
    chk("rs3_we",      32'(ram_we),    32'h0);
    finish_resync();
    run_period(16'h0100, 1'b1, 8'h00, 14'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("rs3_relock",  32'(obs_lk[0]), 32'h1);

    resync_period(2, 16'h0200, 1'b1, 8'h00);
    chk("rs2_rd_hold", 32'(cpu_rdata), 32'h01);
    finish_resync();
    chk("rs2_rd_after",32'(cpu_rdata), 32'h02);

    resync_period(0, 16'h0300, 1'b0, 8'h77);
    chk("rs0_we_drop", 32'(ram_we),    32'h0);
    finish_resync();
    run_period(16'h0300, 1'b1, 8'h00, 14'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("rs0_relock",  32'(obs_lk[0]), 32'h1);
    chk("rs0_readback",32'(obs_rd[3]), 32'h77);

    // Reset landing in slot 1 of a write
    cpu_adr = 16'h0400; cpu_rnw = 1'b0; cpu_wdata = 8'h33; ph_sync = 1'b1;
    step();
    ph_sync = 1'b0;
    step();
    chk("rstw_we_slot1", 32'(ram_we), 32'h1);
    RESET = 1'b1;
    step();
    chk("rstw_we",     32'(ram_we),    32'h0);
    chk("rstw_adr",    32'(ram_adr),   32'h0);
    chk("rstw_locked", 32'(locked),    32'h0);
    chk("rstw_rdata",  32'(cpu_rdata), 32'h00);
    RESET = 1'b0;
    run_period(16'h0400, 1'b1, 8'h00, 14'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("rstw_p1_unlocked", 32'(obs_lk[0]), 32'h0);
    run_period(16'h0400, 1'b1, 8'h00, 14'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("rstw_p2_locked",   32'(obs_lk[0]), 32'h1);
    chk("rstw_written",     32'(obs_rd[3]), 32'h33);

    // Reset coinciding with a sync pulse
    RESET = 1'b1; ph_sync = 1'b1;
    step();
    chk("rstsync_locked", 32'(locked), 32'h0);
    chk("rstsync_we",     32'(ram_we), 32'h0);
    RESET = 1'b0; ph_sync = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
